// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative HI/LO divider: widths, state encodings
// and the result payload layout.
package div_iter_pkg;

   localparam int unsigned DWORD_W    = 32;
   localparam int unsigned DATA_BUS_W = 2 * DWORD_W;
   localparam int unsigned DIV_CNT_W  = 6;

   localparam logic [DIV_CNT_W-1:0] DIV_LAST_ITER = 6'd31;
   localparam logic [DWORD_W-1:0]   DIV_ZERO_QUO  = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_ZERO = 2'd1,
      DIV_BUSY = 2'd2,
      DIV_DONE = 2'd3
   } div_state_e;

   // HI holds the remainder, LO the quotient
   typedef struct packed {
      logic [DWORD_W-1:0] rem;
      logic [DWORD_W-1:0] quo;
   } div_res_t;

endpackage

// File: rtl/div_abs_neg.sv
// Conditional two's-complement negate, used for operand magnitudes and
// for restoring the sign of the quotient and remainder.
module div_abs_neg
   import div_iter_pkg::*;
#(
   parameter int unsigned W = DWORD_W
) (
   input  logic         neg,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout_c
);

   always_comb begin
      dout_c = din;
      if (neg) begin
         dout_c = W'(~din + W'(1));
      end
   end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU. Holds the EX stage via
// stallreq and presents {remainder, quotient} with a one-cycle ready pulse.
module div_iter
   import div_iter_pkg::*;
#(
   parameter int unsigned DW = DWORD_W
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            start,
   input  logic            sgn,
   input  logic [DW-1:0]   opa,
   input  logic [DW-1:0]   opb,
   input  logic            cancel,
   output logic            stallreq,
   output logic            ready,
   output logic [2*DW-1:0] divres
);

   div_state_e            state;
   div_state_e            state_nxt;

   logic [DW-1:0]         rem;
   logic [DW-1:0]         quo;
   logic [DW-1:0]         babs;
   logic                  qneg;
   logic                  rneg;
   logic [DIV_CNT_W-1:0]  cnt;
   logic [DATA_BUS_W-1:0] divres_q;

   logic                  accept_c;
   logic                  opb_zero_c;
   logic                  nega_c;
   logic                  negb_c;
   logic [DW-1:0]         aabs_c;
   logic [DW-1:0]         babs_c;
   logic [DW-1:0]         quo_fix_c;
   logic [DW-1:0]         rem_fix_c;
   logic [DW:0]           shifted_c;
   logic [DW:0]           diff_c;
   logic [DW-1:0]         rem_nxt_c;
   logic [DW-1:0]         quo_nxt_c;
   div_res_t              res_c;

   assign accept_c   = (state == DIV_IDLE) && start && !cancel;
   assign opb_zero_c = (opb == '0);
   assign nega_c     = sgn & opa[DW-1];
   assign negb_c     = sgn & opb[DW-1];

   div_abs_neg #(.W(DW)) u_abs_a (
      .neg    (nega_c),
      .din    (opa),
      .dout_c (aabs_c)
   );

   div_abs_neg #(.W(DW)) u_abs_b (
      .neg    (negb_c),
      .din    (opb),
      .dout_c (babs_c)
   );

   div_abs_neg #(.W(DW)) u_fix_q (
      .neg    (qneg),
      .din    (quo),
      .dout_c (quo_fix_c)
   );

   div_abs_neg #(.W(DW)) u_fix_r (
      .neg    (rneg),
      .din    (rem),
      .dout_c (rem_fix_c)
   );

   // One restoring step: shift in the next dividend bit, trial-subtract |b|
   always_comb begin
      shifted_c = {rem, quo[DW-1]};
      diff_c    = shifted_c - {1'b0, babs};
      rem_nxt_c = diff_c[DW] ? shifted_c[DW-1:0] : diff_c[DW-1:0];
      quo_nxt_c = {quo[DW-2:0], ~diff_c[DW]};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= DIV_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and handshake outputs; divres shows the fresh result in
   // the ready cycle and the held value otherwise
   always_comb begin
      state_nxt = state;
      stallreq  = 1'b0;
      ready     = 1'b0;
      res_c     = divres_q;
      divres    = divres_q;
      case (state)
         DIV_IDLE: begin
            if (accept_c) begin
               stallreq  = 1'b1;
               state_nxt = opb_zero_c ? DIV_ZERO : DIV_BUSY;
            end
         end
         DIV_ZERO: begin
            state_nxt = DIV_IDLE;
            if (!cancel) begin
               ready     = 1'b1;
               res_c.rem = quo;
               res_c.quo = DIV_ZERO_QUO;
            end
         end
         DIV_BUSY: begin
            if (cancel) begin
               state_nxt = DIV_IDLE;
            end else begin
               stallreq = 1'b1;
               if (cnt == DIV_LAST_ITER) begin
                  state_nxt = DIV_DONE;
               end
            end
         end
         DIV_DONE: begin
            state_nxt = DIV_IDLE;
            if (!cancel) begin
               ready     = 1'b1;
               res_c.rem = rem_fix_c;
               res_c.quo = quo_fix_c;
            end
         end
         default: begin
            state_nxt = DIV_IDLE;
         end
      endcase
      if (ready) begin
         divres = res_c;
      end
   end

   // Operand capture, iteration registers and result hold
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rem      <= '0;
         quo      <= '0;
         babs     <= '0;
         qneg     <= 1'b0;
         rneg     <= 1'b0;
         cnt      <= '0;
         divres_q <= '0;
      end else begin
         if (ready) begin
            divres_q <= res_c;
         end
         case (state)
            DIV_IDLE: begin
               if (accept_c) begin
                  rem  <= '0;
                  cnt  <= '0;
                  babs <= babs_c;
                  qneg <= sgn & (opa[DW-1] ^ opb[DW-1]);
                  rneg <= nega_c;
                  // divide-by-zero reports the raw dividend in HI
                  quo  <= opb_zero_c ? opa : aabs_c;
               end
            end
            DIV_BUSY: begin
               if (!cancel) begin
                  rem <= rem_nxt_c;
                  quo <= quo_nxt_c;
                  cnt <= DIV_CNT_W'(cnt + DIV_CNT_W'(1));
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter: results, latency, stall/ready
// handshake, divide-by-zero, cancel and mid-operation reset.
module tb_div_iter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic        sgn;
   logic [31:0] opa;
   logic [31:0] opb;
   logic        cancel;
   logic        stallreq;
   logic        ready;
   logic [63:0] divres;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   div_iter #(.DW(32)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .start    (start),
      .sgn      (sgn),
      .opa      (opa),
      .opb      (opb),
      .cancel   (cancel),
      .stallreq (stallreq),
      .ready    (ready),
      .divres   (divres)
   );

   // Issue one division and wait (bounded) for its ready pulse
   task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output int lat, output int stalls,
                         output logic stall_at_rdy);
      res          = '0;
      lat          = 0;
      stalls       = 0;
      stall_at_rdy = 1'bx;
      @(negedge clk);
      start  = 1'b1;
      sgn    = s;
      opa    = a;
      opb    = b;
      cancel = 1'b0;
      #1;
      if (stallreq === 1'b1) stalls++;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 1; i <= 64; i++) begin
         @(negedge clk);
         if (ready === 1'b1) begin
            lat          = i;
            res          = divres;
            stall_at_rdy = stallreq;
            break;
         end
         if (stallreq === 1'b1) stalls++;
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      start  = 1'b0;
      sgn    = 1'b0;
      opa    = '0;
      opb    = '0;
      cancel = 1'b0;
      #12;
      checks++;
      if (stallreq !== 1'b0) begin errors++; $display("FAIL reset_stallreq: got %b expected 0", stallreq); end
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
      checks++;
      if (divres !== 64'h0) begin errors++; $display("FAIL reset_divres: got %h expected 0", divres); end
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_divu_basic();
      logic [63:0] r; int lat; int st; logic sr;
      do_div(1'b0, 32'd100, 32'd7, r, lat, st, sr);
      checks++;
      if (r !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_100_7: got %h expected %h", r, {32'd2, 32'd14}); end
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL divu_latency: got %0d expected 33", lat); end
      checks++;
      if (st !== 33) begin errors++; $display("FAIL divu_stall_cycles: got %0d expected 33", st); end
      checks++;
      if (sr !== 1'b0) begin errors++; $display("FAIL divu_stall_at_ready: got %b expected 0", sr); end
      @(negedge clk);
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL divu_ready_pulse: got %b expected 0", ready); end
      checks++;
      if (divres !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_hold: got %h expected %h", divres, {32'd2, 32'd14}); end

      do_div(1'b0, 32'hFFFF_FFFF, 32'd1, r, lat, st, sr);
      checks++;
      if (r !== {32'h0, 32'hFFFF_FFFF}) begin errors++; $display("FAIL divu_max_1: got %h expected %h", r, {32'h0, 32'hFFFF_FFFF}); end

      do_div(1'b0, 32'hFFFF_FFF9, 32'd2, r, lat, st, sr);
      checks++;
      if (r !== {32'h1, 32'h7FFF_FFFC}) begin errors++; $display("FAIL divu_fff9_2: got %h expected %h", r, {32'h1, 32'h7FFF_FFFC}); end
   endtask

   task automatic test_div_signed();
      logic [63:0] r; int lat; int st; logic sr;
      do_div(1'b1, 32'hFFFF_FFF9, 32'd2, r, lat, st, sr);
      checks++;
      if (r !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin errors++; $display("FAIL div_m7_2: got %h expected %h", r, {32'hFFFF_FFFF, 32'hFFFF_FFFD}); end
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL div_signed_latency: got %0d expected 33", lat); end

      do_div(1'b1, 32'd7, 32'hFFFF_FFFE, r, lat, st, sr);
      checks++;
      if (r !== {32'h1, 32'hFFFF_FFFD}) begin errors++; $display("FAIL div_7_m2: got %h expected %h", r, {32'h1, 32'hFFFF_FFFD}); end

      do_div(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, r, lat, st, sr);
      checks++;
      if (r !== {32'hFFFF_FFFF, 32'h3}) begin errors++; $display("FAIL div_m7_m2: got %h expected %h", r, {32'hFFFF_FFFF, 32'h3}); end
   endtask

   task automatic test_overflow();
      logic [63:0] r; int lat; int st; logic sr;
      do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, st, sr);
      checks++;
      if (r !== {32'h0, 32'h8000_0000}) begin errors++; $display("FAIL div_overflow: got %h expected %h", r, {32'h0, 32'h8000_0000}); end
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL div_overflow_latency: got %0d expected 33", lat); end
   endtask

   task automatic test_div_zero();
      logic [63:0] r; int lat; int st; logic sr;
      do_div(1'b0, 32'h1234_5678, 32'h0, r, lat, st, sr);
      checks++;
      if (r !== {32'h1234_5678, 32'hFFFF_FFFF}) begin errors++; $display("FAIL divzero_u: got %h expected %h", r, {32'h1234_5678, 32'hFFFF_FFFF}); end
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL divzero_latency: got %0d expected 1", lat); end
      checks++;
      if (st !== 1) begin errors++; $display("FAIL divzero_stall_cycles: got %0d expected 1", st); end
      checks++;
      if (sr !== 1'b0) begin errors++; $display("FAIL divzero_stall_at_ready: got %b expected 0", sr); end

      do_div(1'b1, 32'h8000_0000, 32'h0, r, lat, st, sr);
      checks++;
      if (r !== {32'h8000_0000, 32'hFFFF_FFFF}) begin errors++; $display("FAIL divzero_s: got %h expected %h", r, {32'h8000_0000, 32'hFFFF_FFFF}); end
   endtask

   task automatic test_cancel();
      logic [63:0] r; int lat; int st; logic sr; logic [63:0] prev; int seen;
      do_div(1'b0, 32'd20, 32'd6, r, lat, st, sr);
      prev = {32'd2, 32'd3};
      checks++;
      if (r !== prev) begin errors++; $display("FAIL cancel_setup: got %h expected %h", r, prev); end

      // accept 1000/10, then flush ten cycles into the iteration
      @(negedge clk);
      start = 1'b1; sgn = 1'b0; opa = 32'd1000; opb = 32'd10; cancel = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 1; i <= 10; i++) @(negedge clk);
      cancel = 1'b1;
      #1;
      checks++;
      if (stallreq !== 1'b0) begin errors++; $display("FAIL cancel_stallreq: got %b expected 0", stallreq); end
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL cancel_ready: got %b expected 0", ready); end
      @(posedge clk);
      #1 cancel = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ready === 1'b1 || stallreq === 1'b1) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL cancel_idle: got %0d active cycles expected 0", seen); end
      checks++;
      if (divres !== prev) begin errors++; $display("FAIL cancel_divres_kept: got %h expected %h", divres, prev); end

      do_div(1'b0, 32'd1000, 32'd10, r, lat, st, sr);
      checks++;
      if (r !== {32'd0, 32'd100}) begin errors++; $display("FAIL cancel_restart: got %h expected %h", r, {32'd0, 32'd100}); end
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL cancel_restart_latency: got %0d expected 33", lat); end

      // start qualified by cancel is not accepted
      prev = {32'd0, 32'd100};
      @(negedge clk);
      start = 1'b1; sgn = 1'b0; opa = 32'd55; opb = 32'd0; cancel = 1'b1;
      #1;
      checks++;
      if (stallreq !== 1'b0) begin errors++; $display("FAIL cancel_start_stallreq: got %b expected 0", stallreq); end
      @(posedge clk);
      #1 start = 1'b0; cancel = 1'b0;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (ready === 1'b1 || stallreq === 1'b1) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL cancel_start_ignored: got %0d active cycles expected 0", seen); end
      checks++;
      if (divres !== prev) begin errors++; $display("FAIL cancel_start_divres: got %h expected %h", divres, prev); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] r; int lat; int st; logic sr;
      do_div(1'b0, 32'd100, 32'd7, r, lat, st, sr);
      checks++;
      if (r !== {32'd2, 32'd14}) begin errors++; $display("FAIL b2b_first: got %h expected %h", r, {32'd2, 32'd14}); end
      do_div(1'b1, 32'hFFFF_FFF9, 32'd2, r, lat, st, sr);
      checks++;
      if (r !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin errors++; $display("FAIL b2b_second: got %h expected %h", r, {32'hFFFF_FFFF, 32'hFFFF_FFFD}); end
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL b2b_latency: got %0d expected 33", lat); end
   endtask

   task automatic test_reset_mid();
      logic [63:0] r; int lat; int st; logic sr; int seen;
      @(negedge clk);
      start = 1'b1; sgn = 1'b0; opa = 32'd50; opb = 32'd5; cancel = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 1; i <= 20; i++) @(negedge clk);
      resetn = 1'b0;
      #1;
      checks++;
      if (stallreq !== 1'b0) begin errors++; $display("FAIL rstmid_stallreq: got %b expected 0", stallreq); end
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b expected 0", ready); end
      checks++;
      if (divres !== 64'h0) begin errors++; $display("FAIL rstmid_divres: got %h expected 0", divres); end
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ready === 1'b1) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL rstmid_no_ready: got %0d pulses expected 0", seen); end

      do_div(1'b0, 32'd9, 32'd3, r, lat, st, sr);
      checks++;
      if (r !== {32'd0, 32'd3}) begin errors++; $display("FAIL rstmid_9_3: got %h expected %h", r, {32'd0, 32'd3}); end
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL rstmid_latency: got %0d expected 33", lat); end
   endtask

   initial begin
      test_reset();
      test_divu_basic();
      test_div_signed();
      test_overflow();
      test_div_zero();
      test_cancel();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Iterative radix-2 restoring divider that produces the 64-bit divres consumed by the MEM-stage HI/LO writeback logic for DIV/DIVU.
- Sits in the EX stage beside the multiplier and holds the pipeline via a stall request while it iterates.
- Result packing matches the HI/LO convention: divres[63:32] = remainder (Hi), divres[31:0] = quotient (Lo).

Parameters:
- DW, 32, operand width; only 32 is supported, kept for bench readability.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  EX stage has a DIV/DIVU; sampled only in IDLE.
- sgn  in  1  1 = DIV (signed), 0 = DIVU.
- opa  in  32  dividend.
- opb  in  32  divisor.
- cancel  in  1  pipeline flush (exception/eret); aborts the operation.
- stallreq  out  1  high while an accepted division has not completed.
- ready  out  1  one-cycle pulse; divres is valid.
- divres  out  64  {remainder, quotient}.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, stallreq=0, ready=0, divres=0, all internal registers 0.
- States: IDLE, ZERO, BUSY, DONE.
- IDLE:
  - start=1 & cancel=0 & opb!=0 -> BUSY.
  - start=1 & cancel=0 & opb==0 -> ZERO.
  - Operands and sgn are latched on the accepting edge.
  - stallreq is combinationally high in IDLE when start=1 & cancel=0, so the issuing instruction stalls from its first cycle.
- Operand preparation on accept:
  - Signed: |a|, |b| via two's-complement negate when the MSB is set; record qneg = a[31]^b[31] and rneg = a[31].
  - Unsigned: qneg=0, rneg=0.
- BUSY:
  - 32 iterations, one per cycle, 6-bit counter 0..31.
  - Each iteration: partial remainder {r[31:0], q[31]} is shifted left, then the trial subtraction (33-bit) of |b| is performed. If non-negative, keep the difference and set the quotient LSB to 1; else restore and set it to 0.
  - After iteration 31 -> DONE.
  - stallreq=1 throughout.
- DONE:
  - Apply sign fix: quotient negated if qneg, remainder negated if rneg.
  - Register divres, pulse ready=1 for exactly 1 cycle, drive stallreq=0 in the same cycle so the instruction advances with the result.
  - Next state: IDLE.
- ZERO (divide by zero):
  - Completes in one cycle with divres = {opa_latched, 32'hFFFF_FFFF}, ready=1, then -> IDLE. This applies to signed and unsigned alike.
- Latency: accept edge to ready = 33 cycles (32 BUSY + DONE); divide-by-zero = 1 cycle.
- divres holds its last value until the next DONE/ZERO; it is not cleared on accept.
- Overflow case 0x8000_0000 / 0xFFFF_FFFF signed: the quotient is 0x8000_0000 and the remainder is 0 via natural wrap. No trap is raised.
- cancel:
  - In any state, cancel=1 forces state to IDLE on the next edge, with ready=0 and stallreq=0 in that cycle. divres is unchanged.
  - cancel together with start in IDLE: the request is not accepted.
- start is ignored outside IDLE. The upstream stage holds its operands stable while stalled; the block does not re-sample them.
- Back-to-back: a new start is accepted in the IDLE cycle immediately following DONE.
- Reset asserted mid-operation returns immediately to the reset values, with no ready pulse.

Decomposition:
- Shared defines package gains:
  - state encodings DIV_IDLE, DIV_ZERO, DIV_BUSY, DIV_DONE (2 bits);
  - the existing DWord/DataBus widths;
  - DIV_ZERO_QUO constant (32'hFFFF_FFFF).
- One natural sub-module, div_abs_neg: a 32-bit conditional two's-complement negate. It is instantiated for both operands and both result halves.

Test Plan:
- DIVU 100/7: start in IDLE -> stallreq high 33 cycles, ready at cycle 33, divres = {32'd2, 32'd14}.
- DIV -7/2 (opa=32'hFFFF_FFF9, opb=2) -> divres = {32'hFFFF_FFFF, 32'hFFFF_FFFD}. Repeat with 7/-2 -> {32'h1, 32'hFFFF_FFFD}.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF -> divres = {32'h0, 32'h8000_0000}, no hang, ready after 33 cycles. Also DIVU 32'hFFFF_FFFF/1 -> {0, 32'hFFFF_FFFF}.
- Divide by zero, opa=32'h1234_5678, opb=0 -> ready the cycle after accept, divres = {32'h1234_5678, 32'hFFFF_FFFF}.
- Cancel at iteration 10 -> IDLE next cycle, no ready pulse, divres keeps the prior value. A new start 1 cycle later completes correctly after 33 cycles.
- Assert resetn=0 at iteration 20 -> stallreq, ready and divres go to 0 asynchronously. After release, 9/3 DIVU -> {0, 3}.
